aes_keyschedule_engine: RTL

- Sequential AES key-schedule generator for 128/192/256-bit keys, selected by parameter.
- Expands a cipher key into all Nr+1 round keys, one 32-bit word per step, and stores the words in an internal schedule buffer.
- The cipher core reads any round key by index.
- Successor to the single-step 128-bit key expansion.
- Uses the codebase's synchronous (1-cycle) S-box lookup for SubWord.

---
 rtl/aes_keyschedule_engine.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/aes_keyschedule_engine.sv
// AES-128/192/256 key expansion: one schedule word every two cycles into a
// round-key buffer that the cipher core reads combinationally by round index.
module aes_keyschedule_engine #(
  parameter int KEYBITS = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KEYBITS-1:0] key,
  output logic               busy,
  output logic               done,
  output logic               valid,
  input  logic [3:0]         rd_round,
  output logic [127:0]       rd_key
);
  localparam int NK  = KEYBITS / 32;
  localparam int NR  = NK + 6;
  localparam int NW  = 4 * (NR + 1);
  localparam int KIW = $clog2(NK);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_EXPA = 3'd2;
  localparam logic [2:0] S_EXPB = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  generate
    if (KEYBITS != 128 && KEYBITS != 192 && KEYBITS != 256) begin : g_badKeybits
      $error("aes_keyschedule_engine: KEYBITS must be 128, 192 or 256");
    end
  endgenerate

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  logic [2:0]         r_state;
  logic [5:0]         r_i;
  logic [2:0]         r_j;
  logic [7:0]         r_rcon;
  logic               r_valid;
  logic [KEYBITS-1:0] r_key;
  logic [31:0]        r_w [NW];
  logic [31:0]        r_sub;

  logic [31:0] w_prev;
  logic [31:0] w_t;
  logic [31:0] w_f;
  logic [7:0]  w_rconNext;
  logic [31:0] w_keyWord [NK];

  genvar g;
  for (g = 0; g < NK; g++) begin : g_keyWord
    assign w_keyWord[g] = r_key[KEYBITS-1-32*g -: 32];
  end

  // r_j tracks i mod Nk so no divider is needed on the step counter.
  assign w_prev     = r_w[r_i - 6'd1];
  assign w_t        = (r_j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign w_rconNext = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  always_comb begin
    w_f = w_prev;
    if (r_j == 3'd0) begin
      w_f = r_sub ^ {r_rcon, 24'h0};
    end else if (NK == 8 && r_j == 3'd4) begin
      w_f = r_sub;
    end
  end

  always_ff @(posedge clk) begin
    r_sub <= {sbox(w_t[31:24]), sbox(w_t[23:16]), sbox(w_t[15:8]), sbox(w_t[7:0])};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_rcon  <= 8'h01;
      r_i     <= '0;
      r_j     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key   <= key;
            r_valid <= 1'b0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_i     <= 6'(NK);
          r_j     <= 3'd0;
          r_rcon  <= 8'h01;
          r_state <= S_EXPA;
        end
        S_EXPA: r_state <= S_EXPB;
        S_EXPB: begin
          // Hold rcon at its last legal value (0x36) instead of stepping past it.
          if (r_j == 3'd0 && r_rcon != 8'h36) r_rcon <= w_rconNext;
          r_i <= r_i + 6'd1;
          r_j <= (r_j == 3'(NK-1)) ? 3'd0 : r_j + 3'd1;
          if (r_i == 6'(NW-1)) begin
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_EXPA;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      for (int k = 0; k < NK; k++) r_w[6'(k)] <= w_keyWord[KIW'(k)];
    end else if (r_state == S_EXPB) begin
      r_w[r_i] <= r_w[r_i - 6'(NK)] ^ w_f;
    end
  end

  assign busy  = (r_state == S_LOAD) || (r_state == S_EXPA) || (r_state == S_EXPB);
  assign done  = (r_state == S_DONE);
  assign valid = r_valid;

  always_comb begin
    rd_key = '0;
    if (r_valid && rd_round <= 4'(NR)) begin
      rd_key = {r_w[{rd_round, 2'b00}], r_w[{rd_round, 2'b01}],
                r_w[{rd_round, 2'b10}], r_w[{rd_round, 2'b11}]};
    end
  end
endmodule
